// File: rtl/id_decode_buf.sv
// Decode stage buffer: classifies and extracts the immediate of each fetched instruction,
// then holds up to two decoded entries in a main/skid pair with a registered in_ready.
module id_decode_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm,
    output logic [2:0]  out_type,
    output logic        out_illegal
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;

    logic [2:0]  dec_type;
    logic        dec_illegal;
    logic [31:0] dec_imm;
    entry_t      dec_entry;
    logic        accept;
    logic        consume;

    always_comb begin
        dec_type    = 3'b000;
        dec_illegal = 1'b0;
        case (in_inst[6:0])
            7'b0000011, 7'b0000111, 7'b1100111, 7'b1110011: dec_type = 3'b001;
            7'b0010011:                                     dec_type = 3'b110;
            7'b0110111, 7'b0010111:                         dec_type = 3'b010;
            7'b1100011:                                     dec_type = 3'b011;
            7'b0100011, 7'b0100111:                         dec_type = 3'b100;
            7'b1101111:                                     dec_type = 3'b101;
            default:                                        dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_imm = 32'h0;
        case (dec_type)
            3'b001: dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            3'b110: begin
                // Shift-immediate forms carry only a 5-bit shamt in the immediate
                if (in_inst[14:12] == 3'b001 || in_inst[14:12] == 3'b101) begin
                    dec_imm = {{27{in_inst[31]}}, in_inst[24:20]};
                end else begin
                    dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            3'b010: dec_imm = {in_inst[31:12], 12'b0};
            3'b011: dec_imm = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                               in_inst[11:8], 1'b0};
            3'b100: dec_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            3'b101: dec_imm = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20],
                               in_inst[30:21], 1'b0};
            default: dec_imm = 32'h0;
        endcase
    end

    assign dec_entry = '{inst: in_inst, pc: in_pc, imm: dec_imm, typ: dec_type,
                         illegal: dec_illegal};

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = dec_entry;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && consume) begin
                        main_d = dec_entry;
                    end else if (accept) begin
                        skid_d  = dec_entry;
                        state_d = StFull;
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        // Registered ready: depends only on the next state, never on out_ready directly
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != StEmpty);
    assign out_inst    = main_q.inst;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_type    = main_q.typ;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_id_decode_buf.sv
// Bench for id_decode_buf: directed decode/backpressure/flush/reset scenarios plus a random
// run checked against a queue-based reference of the buffer.
module tb_id_decode_buf;

    logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_pc, out_inst, out_pc, out_imm;
    logic [2:0]  out_type;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } ent_t;

    ent_t mq[$];
    logic m_rdy = 1'b0;

    id_decode_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_imm    (out_imm),
        .out_type   (out_type),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        ent_t        e;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [5:0]  sh6;
        e.inst = i;
        e.pc   = pc;
        e.ill  = 1'b0;
        e.imm  = 32'h0;
        case (i[6:0])
            7'h03, 7'h07, 7'h67, 7'h73: e.typ = 3'd1;
            7'h13:                      e.typ = 3'd6;
            7'h37, 7'h17:               e.typ = 3'd2;
            7'h63:                      e.typ = 3'd3;
            7'h23, 7'h27:               e.typ = 3'd4;
            7'h6F:                      e.typ = 3'd5;
            default: begin e.typ = 3'd0; e.ill = 1'b1; end
        endcase
        i12 = i[31:20];
        sh6 = {i[31], i[24:20]};
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (e.typ)
            3'd1: e.imm = int'($signed(i12));
            3'd6: e.imm = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? int'($signed(sh6))
                                                                   : int'($signed(i12));
            3'd2: e.imm = i & 32'hFFFF_F000;
            3'd3: e.imm = int'($signed(b13));
            3'd4: begin i12 = {i[31:25], i[11:7]}; e.imm = int'($signed(i12)); end
            3'd5: e.imm = int'($signed(j21));
            default: e.imm = 32'h0;
        endcase
        return e;
    endfunction

    task automatic model_edge();
        logic acc, con;
        if (!rst_n) begin
            mq.delete();
            m_rdy = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_rdy = 1'b1;
        end else begin
            acc = in_valid && m_rdy;
            con = (mq.size() > 0) && out_ready;
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(ref_decode(in_inst, in_pc));
            m_rdy = (mq.size() < 2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00)
            $display("FAIL reset_flags: got %b want 00", {out_valid, in_ready});
        else passed++;
        checks++;
        if ({out_inst, out_pc, out_imm, out_type, out_illegal} !== 100'h0)
            $display("FAIL reset_data: got %h want 0",
                     {out_inst, out_pc, out_imm, out_type, out_illegal});
        else passed++;
        @(negedge clk);
        tick();
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_hold_ready: got %b want 0", in_ready);
        else passed++;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_release: got %b want 10", {in_ready, out_valid});
        else passed++;
    endtask

    task automatic test_decode();
        logic [31:0] vin [5];
        logic [2:0]  vty [5];
        logic [31:0] vim [5];
        logic        vil [5];
        vin = '{32'hFFF00093, 32'h4030D093, 32'h008000EF, 32'hFE000EE3, 32'h0000007F};
        vty = '{3'b110, 3'b110, 3'b101, 3'b011, 3'b000};
        vim = '{32'hFFFFFFFF, 32'h00000003, 32'h00000008, 32'hFFFFFFFC, 32'h0};
        vil = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_inst  = vin[k];
            in_pc    = 32'h1000 + 32'(k * 4);
            tick();
            in_valid = 1'b0;
            checks++;
            if ({out_valid, out_inst, out_pc} !== {1'b1, vin[k], 32'h1000 + 32'(k * 4)})
                $display("FAIL dec_entry_%0d: got %b %h %h want 1 %h %h", k, out_valid,
                         out_inst, out_pc, vin[k], 32'h1000 + 32'(k * 4));
            else passed++;
            checks++;
            if ({out_type, out_imm, out_illegal} !== {vty[k], vim[k], vil[k]})
                $display("FAIL dec_fields_%0d: got %b %h %b want %b %h %b", k, out_type,
                         out_imm, out_illegal, vty[k], vim[k], vil[k]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00100093;
        in_pc     = 32'h100;
        tick();
        in_inst = 32'h00200113;
        in_pc   = 32'h104;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 32'h100})
            $display("FAIL full_hold: got %b %b %h want 0 1 100", in_ready, out_valid, out_pc);
        else passed++;
        tick();
        checks++;
        if (out_pc !== 32'h100) $display("FAIL stall_stable: got %h want 100", out_pc);
        else passed++;
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h104})
            $display("FAIL drain_second: got %b %h want 1 104", out_valid, out_pc);
        else passed++;
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h300;
        in_inst   = 32'h00000013;
        tick();
        in_pc = 32'h304;
        tick();
        flush   = 1'b1;
        in_pc   = 32'h200;
        in_inst = 32'h00500293;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL flush_state: got %b want 01", {out_valid, in_ready});
        else passed++;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) $display("FAIL flush_dropped_%0d: got %b want 0", k,
                                             out_valid);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00000013;
        in_pc     = 32'h400;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) $display("FAIL pre_reset_one: got %b want 1", out_valid);
        else passed++;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_rdy = 1'b0;
        checks++;
        if ({out_valid, in_ready, out_pc} !== {2'b00, 32'h0})
            $display("FAIL async_reset: got %b %b %h want 0 0 0", out_valid, in_ready, out_pc);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL post_reset: got %b want 01", {out_valid, in_ready});
        else passed++;
    endtask

    task automatic test_random();
        logic [6:0]  opc [12];
        logic [31:0] r;
        ent_t        h;
        opc = '{7'h03, 7'h07, 7'h67, 7'h73, 7'h13, 7'h37, 7'h17, 7'h63, 7'h23, 7'h27,
                7'h6F, 7'h33};
        for (int n = 0; n < 600; n++) begin
            r        = $urandom();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            in_inst  = {r[31:7], opc[$urandom_range(0, 11)]};
            in_pc    = $urandom() & 32'hFFFF_FFFC;
            tick();
            checks++;
            if ({out_valid, in_ready} !== {mq.size() != 0, m_rdy})
                $display("FAIL rnd_flags_%0d: got %b%b want %b%b", n, out_valid, in_ready,
                         mq.size() != 0, m_rdy);
            else passed++;
            if (mq.size() != 0) begin
                h = mq[0];
                checks++;
                if ({out_inst, out_pc, out_imm, out_type, out_illegal} !==
                    {h.inst, h.pc, h.imm, h.typ, h.ill})
                    $display("FAIL rnd_data_%0d: got %h %h %h %b %b want %h %h %h %b %b", n,
                             out_inst, out_pc, out_imm, out_type, out_illegal,
                             h.inst, h.pc, h.imm, h.typ, h.ill);
                else passed++;
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/id_decode_buf.md
ID_DECODE_BUF -- requirements
Module: id_decode_buf

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, fetch offers an instruction.
REQ-004 SHALL have port in_ready, output, 1, block accepts the instruction this cycle.
REQ-005 SHALL have port in_inst, input, 32, raw instruction word.
REQ-006 SHALL have port in_pc, input, 32, instruction address.
REQ-007 SHALL have port flush, input, 1, discard all held entries (branch mispredict or trap).
REQ-008 SHALL have port out_valid, output, 1, decoded entry available.
REQ-009 SHALL have port out_ready, input, 1, execute stage consumes the entry.
REQ-010 SHALL have ports out_inst, out_pc, and out_imm, each output, 32, registered instruction, pc, and immediate.
REQ-011 SHALL have port out_type, output, 3, immediate-format code.
REQ-012 SHALL have port out_illegal, output, 1, opcode not recognised.

Function
REQ-013 SHALL classify in_inst[6:0] combinationally into a type code:
- 0000011, 0000111, 1100111, 1110011 -> 001
- 0010011 -> 110
- 0110111, 0010111 -> 010
- 1100011 -> 011
- 0100011, 0100111 -> 100
- 1101111 -> 101
- all other opcodes -> 000 with illegal=1
REQ-014 SHALL form the immediate by type code:
- 001: sign-extended inst[31:20]
- 110 with funct3 001/101: {27{inst[31]}, inst[24:20]}; 110 with any other funct3: as 001
- 010: {inst[31:12], 12'b0}
- 011: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}
- 100: sign-extended {inst[31:25], inst[11:7]}
- 101: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- 000: immediate 0
REQ-015 SHALL store the decoded fields (inst, pc, imm, type, illegal), never recompute them at output.
REQ-016 SHALL implement a 2-entry skid buffer: a MAIN register drives the out_* ports, and a SKID register holds overflow.
REQ-017 SHALL use states EMPTY (no entry), ONE (MAIN valid), and FULL (MAIN and SKID valid); out_valid=1 in ONE and FULL.
REQ-018 SHALL drive in_ready=1 in EMPTY and ONE and in_ready=0 in FULL; in_ready SHALL come from a register with no combinational path from out_ready.
REQ-019 SHALL define accept = in_valid&in_ready and consume = out_valid&out_ready.
REQ-020 SHALL apply these transitions:
- EMPTY + accept -> ONE (MAIN loaded)
- ONE + accept + consume -> ONE (MAIN reloaded)
- ONE + accept, no consume -> FULL (SKID loaded)
- ONE + consume, no accept -> EMPTY
- FULL + consume -> ONE (SKID moves to MAIN)
- all other cases hold state
REQ-021 SHALL make latency one cycle: an instruction accepted at edge N is visible on out_* after edge N when the buffer was EMPTY.
REQ-022 SHALL deliver entries strictly in acceptance order, without loss or duplication.
REQ-023 SHALL make flush take priority over accept and consume in the same cycle: next state EMPTY, in_ready=1, and the input offered that cycle is dropped.
REQ-024 SHALL hold out_* data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL pass illegal instructions through as normal entries with out_illegal=1; the block SHALL NOT stall on them.

Reset
REQ-026 SHALL, while rst_n=0, force state EMPTY, out_valid=0, in_ready=0, out_inst/out_pc/out_imm=0, out_type=000, and out_illegal=0, independent of clk.
REQ-027 SHALL set in_ready=1 on the first rising clk after rst_n deasserts.
REQ-028 SHALL discard any held entries when reset is asserted mid-operation, with no output after release until a new accept.

Verification
REQ-029 SHALL cover: in_inst=0xFFF00093, EMPTY, out_ready=1 -> next cycle out_type=110, out_imm=0xFFFFFFFF, out_illegal=0.
REQ-030 SHALL cover: in_inst=0x4030D093 (srai by 3) -> out_type=110, out_imm=0x00000003.
REQ-031 SHALL cover:
- in_inst=0x008000EF -> out_type=101, out_imm=0x00000008
- in_inst=0xFE000EE3 -> out_type=011, out_imm=0xFFFFFFFC
REQ-032 SHALL cover:
- Stimulus: out_ready=0 while A (pc 0x100) and B (pc 0x104) are accepted on consecutive cycles.
- Required: in_ready=0 in the following cycle; out_pc holds 0x100.
- Then: out_ready=1 for two cycles -> 0x100, then 0x104, then out_valid=0.
REQ-033 SHALL cover: FULL state with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the offered instruction is never output.
REQ-034 SHALL cover: in_inst=0x0000007F -> out_illegal=1, out_type=000, out_imm=0; rst_n pulsed low while ONE -> out_valid=0 immediately.
